// File: rtl/parity_frame_tx_if.sv
// Word-side valid/ready handshake between the word source and parity_frame_tx.
// The master offers words; the slave (the transmitter) accepts them.
interface parity_frame_tx_if #(
  parameter int PAIRS = 4
);
  logic               s_valid;
  logic               s_ready;
  logic [2*PAIRS-1:0] s_data;
  logic               s_err_inj;

  modport master (output s_valid, s_data, s_err_inj, input s_ready);
  modport slave  (input  s_valid, s_data, s_err_inj, output s_ready);
endinterface

// File: rtl/parity_frame_tx.sv
// Serialises a word of 2-bit pairs into back-to-back 3-bit frames (hi, lo, parity)
// for the 3-bit-frame parity detector; pair PAIRS-1 goes first.
module parity_frame_tx #(
  parameter int PAIRS      = 4,
  parameter bit ODD_PARITY = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  parity_frame_tx_if.slave    s,
  input  logic                bit_en,
  output logic                tx_bit,
  output logic                tx_valid,
  output logic                tx_frame_start,
  output logic                tx_parity_slot,
  output logic                busy,
  output logic                word_done,
  output logic [7:0]          frame_cnt
);

  localparam int IW = (PAIRS > 1) ? $clog2(PAIRS) : 1;

  typedef enum logic [1:0] {IDLE, D_HI, D_LO, PAR} state_t;

  state_t             r_state;
  logic [2*PAIRS-1:0] r_word;
  logic [IW-1:0]      r_idx;
  logic               r_err;
  logic               r_ready;
  logic               r_tx_bit;
  logic               r_tx_valid;
  logic               r_frame_start;
  logic               r_parity_slot;
  logic               r_busy;
  logic               r_word_done;
  logic [7:0]         r_frame_cnt;

  // The pair being sent always sits in the top two bits of the shift register.
  logic [1:0]         w_pair;
  logic [2*PAIRS-1:0] w_next_word;

  assign w_pair      = r_word[2*PAIRS-1 -: 2];
  assign w_next_word = r_word << 2;

  // NOTE: every register here, the shift register included, is cleared by the
  // synchronous reset and updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_word        <= '0;
      r_idx         <= '0;
      r_err         <= 1'b0;
      r_ready       <= 1'b1;
      r_tx_bit      <= 1'b0;
      r_tx_valid    <= 1'b0;
      r_frame_start <= 1'b0;
      r_parity_slot <= 1'b0;
      r_busy        <= 1'b0;
      r_word_done   <= 1'b0;
      r_frame_cnt   <= 8'd0;
    end else begin
      r_word_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (s.s_valid) begin
            r_state       <= D_HI;
            r_word        <= s.s_data;
            r_err         <= s.s_err_inj;
            r_idx         <= IW'(PAIRS - 1);
            r_ready       <= 1'b0;
            r_busy        <= 1'b1;
            r_tx_bit      <= s.s_data[2*PAIRS-1];
            r_tx_valid    <= 1'b1;
            r_frame_start <= 1'b1;
          end
        end
        D_HI: begin
          if (bit_en) begin
            r_state       <= D_LO;
            r_tx_bit      <= w_pair[0];
            r_frame_start <= 1'b0;
          end
        end
        D_LO: begin
          if (bit_en) begin
            r_state       <= PAR;
            // r_err is only ever set for the first frame of a word.
            r_tx_bit      <= w_pair[1] ^ w_pair[0] ^ ODD_PARITY ^ r_err;
            r_parity_slot <= 1'b1;
          end
        end
        PAR: begin
          if (bit_en) begin
            r_frame_cnt   <= r_frame_cnt + 8'd1;
            r_parity_slot <= 1'b0;
            r_err         <= 1'b0;
            if (r_idx == '0) begin
              r_state     <= IDLE;
              r_ready     <= 1'b1;
              r_busy      <= 1'b0;
              r_tx_bit    <= 1'b0;
              r_tx_valid  <= 1'b0;
              r_word_done <= 1'b1;
            end else begin
              r_state       <= D_HI;
              r_idx         <= r_idx - 1'b1;
              r_word        <= w_next_word;
              r_tx_bit      <= w_next_word[2*PAIRS-1];
              r_frame_start <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s.s_ready      = r_ready;
  assign tx_bit         = r_tx_bit;
  assign tx_valid       = r_tx_valid;
  assign tx_frame_start = r_frame_start;
  assign tx_parity_slot = r_parity_slot;
  assign busy           = r_busy;
  assign word_done      = r_word_done;
  assign frame_cnt      = r_frame_cnt;

endmodule
